// File: rtl/timer_pkg.sv
//==============================================================================
// Module      : timer_pkg
// Description : Shared state encoding, BCD digit limits and load validation
//               for the mm:ss stopwatch / countdown timer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package timer_pkg;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // BCD digit limits
    localparam logic [3:0] BCD_NINE     = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Minute value at which an up-count wraps back to 00:00
    localparam logic [7:0] DEFAULT_MAX_MIN = 8'h59;

    // A load value is accepted only when every digit is legal BCD, the
    // seconds field is at most 59 and the minutes field does not exceed the
    // wrap point. Because legal packed BCD orders the same way as binary, a
    // plain magnitude compare works for the minutes bound.
    function automatic logic load_is_valid(
        input logic [7:0] min_v,
        input logic [7:0] sec_v,
        input logic [7:0] max_min
    );
        return (min_v[3:0] <= BCD_NINE) &&
               (sec_v[3:0] <= BCD_NINE) &&
               (sec_v[7:4] <= SEC_TENS_MAX) &&
               (min_v <= max_min);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_pair.sv
//==============================================================================
// Module      : bcd_digit_pair
// Description : Two-digit packed BCD up/down counter with programmable digit
//               limits. Rolls to 00 (up) or to the limits (down) and flags
//               a carry/borrow on the step that rolls over.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_digit_pair (
    input  logic       clk,
    input  logic       reset,      // asynchronous, active-low
    input  logic       en,         // advance one step this cycle
    input  logic       up,         // 1 = increment, 0 = decrement
    input  logic       load,       // synchronous load, has priority over en
    input  logic [7:0] load_val,
    input  logic [3:0] tens_max,
    input  logic [3:0] units_max,
    output logic [7:0] value,
    output logic       carry       // carry (up) or borrow (down) out
);

    logic [3:0] units;
    logic [3:0] tens;
    logic       units_term;
    logic       tens_term;
    logic [3:0] units_nxt;
    logic [3:0] tens_nxt;

    assign units = value[3:0];
    assign tens  = value[7:4];

    // Terminal digit detection: the limit when counting up, zero when down
    always_comb begin
        units_term = up ? (units == units_max) : (units == 4'd0);
        tens_term  = up ? (tens == tens_max)   : (tens == 4'd0);
    end

    assign carry = en & units_term & tens_term;

    // Next digit values: units always move, tens move only on a units rollover
    always_comb begin
        units_nxt = units;
        tens_nxt  = tens;
        if (units_term) begin
            units_nxt = up ? 4'd0 : units_max;
            if (tens_term) begin
                tens_nxt = up ? 4'd0 : tens_max;
            end else begin
                tens_nxt = up ? (tens + 4'd1) : (tens - 4'd1);
            end
        end else begin
            units_nxt = up ? (units + 4'd1) : (units - 4'd1);
        end
    end

    // Count register: load beats a count step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= 8'h00;
        end else if (load) begin
            value <= load_val;
        end else if (en) begin
            value <= {tens_nxt, units_nxt};
        end
    end

endmodule

`default_nettype wire

// File: rtl/sec_min_counter.sv
//==============================================================================
// Module      : sec_min_counter
// Description : mm:ss stopwatch / countdown timer in packed BCD, advanced by
//               the rising edges of a 1 Hz square wave from the divider.
//               Provides done (countdown hit 00:00), wrap (up-count rolled
//               over) and load_err (rejected load) pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sec_min_counter
    import timer_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,              // must be at least 2
    parameter logic [7:0] MAX_MIN     = DEFAULT_MAX_MIN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       run,
    input  logic       up_dn,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       wrap,
    output logic       load_err
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic [SYNC_STAGES-1:0] sync_vld;
    logic                   tick_sync;
    logic                   sample_ok;
    logic                   tick_prev;
    logic                   armed;
    logic                   sec_en;

    logic [1:0]             state;
    logic [1:0]             state_nxt;

    logic                   load_valid;
    logic                   load_ok;
    logic                   load_bad;
    logic                   tick;
    logic                   at_zero;
    logic                   at_one;
    logic                   hold_zero;
    logic                   done_ev;
    logic                   sec_step;
    logic                   sec_carry;
    logic                   min_carry;
    logic [3:0]             min_units_lim;

    logic                   running_nxt;
    logic                   done_nxt;
    logic                   wrap_nxt;
    logic                   load_err_nxt;

    //--------------------------------------------------------------------------
    // Tick synchroniser and rising-edge detector.
    // sync_vld tracks which sync stages hold a genuine sample of tick_in
    // rather than reset zeros. The detector only arms after a genuine low
    // sample, so a tick_in that is already high when reset releases is not
    // mistaken for a new second.
    //--------------------------------------------------------------------------
    assign tick_sync = sync_ff[SYNC_STAGES-1];
    assign sample_ok = sync_vld[SYNC_STAGES-1];
    assign sec_en    = armed & tick_sync & ~tick_prev;

    // Synchroniser chain, sample-valid chain and edge-detector history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff   <= '0;
            sync_vld  <= '0;
            tick_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], tick_in};
            sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            tick_prev <= tick_sync;
            armed     <= armed | (sample_ok & ~tick_sync);
        end
    end

    //--------------------------------------------------------------------------
    // Count control. A load strobe (valid or not) swallows a coincident tick.
    //--------------------------------------------------------------------------
    assign load_valid = load_is_valid(load_min, load_sec, MAX_MIN);
    assign load_ok    = load & load_valid;
    assign load_bad   = load & ~load_valid;

    assign tick      = sec_en & run & (state == ST_RUN) & ~load;
    assign at_zero   = (min_bcd == 8'h00) && (sec_bcd == 8'h00);
    assign at_one    = (min_bcd == 8'h00) && (sec_bcd == 8'h01);
    assign hold_zero = tick & ~up_dn & at_zero;
    assign sec_step  = tick & ~hold_zero;
    assign done_ev   = tick & ~up_dn & (at_zero | at_one);

    // When counting up inside the top minutes decade, the minutes units stop
    // at MAX_MIN's units digit so that the minute pair's carry marks the wrap
    // point exactly and the pair itself rolls to 00. Down-counts never borrow
    // out of 00 minutes, so they can always use 9.
    assign min_units_lim = (up_dn && (min_bcd[7:4] == MAX_MIN[7:4])) ?
                           MAX_MIN[3:0] : BCD_NINE;

    bcd_digit_pair u_sec_pair (
        .clk       (clk),
        .reset     (reset),
        .en        (sec_step),
        .up        (up_dn),
        .load      (load_ok),
        .load_val  (load_sec),
        .tens_max  (SEC_TENS_MAX),
        .units_max (BCD_NINE),
        .value     (sec_bcd),
        .carry     (sec_carry)
    );

    bcd_digit_pair u_min_pair (
        .clk       (clk),
        .reset     (reset),
        .en        (sec_carry),
        .up        (up_dn),
        .load      (load_ok),
        .load_val  (load_min),
        .tens_max  (MAX_MIN[7:4]),
        .units_max (min_units_lim),
        .value     (min_bcd),
        .carry     (min_carry)
    );

    //--------------------------------------------------------------------------
    // Controller FSM
    //--------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a valid load resolves to RUN or IDLE from any state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load_ok) begin
                    state_nxt = run ? ST_RUN : ST_IDLE;
                end else if (run) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_ok) begin
                    state_nxt = run ? ST_RUN : ST_IDLE;
                end else if (done_ev) begin
                    state_nxt = ST_DONE;
                end else if (!run) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (load_ok) begin
                    state_nxt = run ? ST_RUN : ST_IDLE;
                end else if (!run) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode, registered below so every status output is a flop
    always_comb begin
        running_nxt  = (state_nxt == ST_RUN);
        done_nxt     = done_ev;
        wrap_nxt     = min_carry & up_dn;
        load_err_nxt = load_bad;
    end

    // Status output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running  <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            running  <= running_nxt;
            done     <= done_nxt;
            wrap     <= wrap_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule

`default_nettype wire
